// File: rtl/phivers_stream_feeder_pkg.sv
// Shared types and defaults for the phivers stream feeder.
package phivers_stream_feeder_pkg;
  typedef enum logic [1:0] {FEED_IDLE, FEED_FETCH, FEED_DRAIN} feeder_state_e;
  localparam int FEEDER_DEF_DEPTH = 4;
  localparam int FEEDER_WORD_W    = 32;
endpackage

// File: rtl/phivers_stream_feeder_if.sv
// Control, image-memory and Hermes source link of the stream feeder.
// PHIVERS_FEEDER_CKSUM_EN adds the cksum_o signal.
interface phivers_stream_feeder_if #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 24
);
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [LEN_W-1:0]  length_i;
  logic              busy_o;
  logic              done_o;
  logic              mem_en_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_data_i;
  logic              src_rx_o;
  logic              src_credit_i;
  logic [31:0]       src_data_o;
`ifdef PHIVERS_FEEDER_CKSUM_EN
  logic [31:0]       cksum_o;

  modport master (
    input  start_i, base_addr_i, length_i, mem_data_i, src_credit_i,
    output busy_o, done_o, mem_en_o, mem_addr_o, src_rx_o, src_data_o, cksum_o
  );
  modport slave (
    output start_i, base_addr_i, length_i, mem_data_i, src_credit_i,
    input  busy_o, done_o, mem_en_o, mem_addr_o, src_rx_o, src_data_o, cksum_o
  );
`else
  modport master (
    input  start_i, base_addr_i, length_i, mem_data_i, src_credit_i,
    output busy_o, done_o, mem_en_o, mem_addr_o, src_rx_o, src_data_o
  );
  modport slave (
    output start_i, base_addr_i, length_i, mem_data_i, src_credit_i,
    input  busy_o, done_o, mem_en_o, mem_addr_o, src_rx_o, src_data_o
  );
`endif
endinterface

// File: rtl/phivers_stream_feeder_fifo.sv
// Prefetch FIFO: synchronous, head visible combinationally from storage.
// A push into a full FIFO is accepted only when a pop happens the same cycle.
module feeder_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [WIDTH-1:0]       head_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/phivers_stream_feeder.sv
// Stream feeder: reads LENGTH words from image memory starting at BASE and
// streams them on a rx/credit/data link. Reads are throttled so that words in
// the FIFO plus the one read in flight never exceed FIFO_DEPTH.
// Optional PHIVERS_FEEDER_CKSUM_EN: running XOR of accepted words on cksum_o.
module phivers_stream_feeder
  import phivers_stream_feeder_pkg::*;
#(
  parameter int FIFO_DEPTH = FEEDER_DEF_DEPTH,
  parameter int ADDR_W     = 24,
  parameter int LEN_W      = 24
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  phivers_stream_feeder_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  feeder_state_e     state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q, issued_q, accepted_q;
  logic              inflight_q, done_q, mem_en;
  logic              fifo_full, fifo_empty, hs, last_acc, rd_room;
  logic [CW-1:0]     fifo_count;
  logic [31:0]       fifo_head;

  feeder_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FEEDER_WORD_W)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (inflight_q),
    .pop_i   (bus.src_credit_i),
    .data_i  (bus.mem_data_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  assign hs       = !fifo_empty && bus.src_credit_i;
  assign last_acc = hs && (accepted_q + LEN_W'(1) == len_q);
  assign rd_room  = (int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= FEED_IDLE;
    else       state_q <= state_d;
  end

  // Next state and read strobe.
  always_comb begin
    state_d = state_q;
    mem_en  = 1'b0;
    case (state_q)
      FEED_IDLE: begin
        if (bus.start_i && bus.length_i != '0) state_d = FEED_FETCH;
      end
      FEED_FETCH: begin
        mem_en = (issued_q != len_q) && rd_room && !fifo_full;
        if (mem_en && (issued_q + LEN_W'(1) == len_q)) state_d = FEED_DRAIN;
      end
      FEED_DRAIN: begin
        if (last_acc) state_d = FEED_IDLE;
      end
      default: state_d = FEED_IDLE;
    endcase
  end

  // Transfer parameters, counters, in-flight flag and done pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= mem_en;
      if (state_q == FEED_IDLE && bus.start_i) begin
        base_q     <= bus.base_addr_i;
        len_q      <= bus.length_i;
        issued_q   <= '0;
        accepted_q <= '0;
        done_q     <= (bus.length_i == '0);
      end else begin
        if (mem_en)   issued_q   <= issued_q + LEN_W'(1);
        if (hs)       accepted_q <= accepted_q + LEN_W'(1);
        if (last_acc) done_q     <= 1'b1;
      end
    end
  end

  assign bus.busy_o     = (state_q != FEED_IDLE);
  assign bus.done_o     = done_q;
  assign bus.mem_en_o   = mem_en;
  assign bus.mem_addr_o = mem_en ? base_q + ADDR_W'(issued_q) : '0;
  assign bus.src_rx_o   = !fifo_empty;
  assign bus.src_data_o = fifo_empty ? '0 : fifo_head;

`ifdef PHIVERS_FEEDER_CKSUM_EN
  logic [31:0] cksum_q;

  // Checksum: cleared by an accepted start, folds in every handshaked word.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                   cksum_q <= '0;
    else if (state_q == FEED_IDLE && bus.start_i) cksum_q <= '0;
    else if (hs)                                 cksum_q <= cksum_q ^ bus.src_data_o;
  end

  assign bus.cksum_o = cksum_q;
`endif
endmodule

// File: tb/tb_phivers_stream_feeder.sv
// Bench for phivers_stream_feeder: image-memory model, expected-word queue
// per transfer, address / ordering / hold / occupancy / latency checks.
module tb_phivers_stream_feeder;
  localparam int AW = 24, LW = 24, DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phivers_stream_feeder_if #(.ADDR_W(AW), .LEN_W(LW)) bus ();
  phivers_stream_feeder #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int ncmp = 0, nfail = 0;
  int mem_mode = 0;
  logic [31:0] mem_seed = 32'h1234_5678;

  function automatic logic [31:0] mem_word(logic [23:0] a);
    case (mem_mode)
      0:       return {8'h0, a};
      1:       return ({8'h0, a} * 32'h9E37_79B1) ^ mem_seed;
      default: return 32'h1 << a[1:0];
    endcase
  endfunction

  // Image memory, one-cycle read latency.
  always @(posedge clk) if (bus.mem_en_o) bus.mem_data_i <= mem_word(bus.mem_addr_o);

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int cyc_n = 0, start_cyc = -100, poke_cyc = -1;
  int n_issued, n_acc, first_rx, first_en, last_hs, done_cyc, cur_len, cmode;
  logic [23:0] cur_base;
  logic [31:0] exp_q[$];
  logic [31:0] ck_m, held_data;
  logic held, saw_busy, pend_start = 1'b0;

  // One cycle: drive at negedge, observe 1 time unit later.
  task automatic step();
    logic rx, cr;
    logic [31:0] d, e;
    logic [23:0] ea;
    @(negedge clk);
    cyc_n++;
    bus.start_i = pend_start;
    if (pend_start) start_cyc = cyc_n;
    pend_start = 1'b0;
    if (cyc_n == poke_cyc) begin
      bus.start_i = 1'b1; bus.base_addr_i = 24'h555555; bus.length_i = 24'd3;
    end
    case (cmode)
      0:       cr = 1'b1;
      1:       cr = (cyc_n % 2 == 0);
      default: cr = 1'($urandom_range(0, 1));
    endcase
    bus.src_credit_i = cr;
    #1;
    rx = bus.src_rx_o;
    d  = bus.src_data_o;
    saw_busy = saw_busy | bus.busy_o;
`ifdef PHIVERS_FEEDER_CKSUM_EN
    if (cyc_n == start_cyc + 1) chk("cksum_clear", bus.cksum_o, 32'h0);
`endif
    if (bus.mem_en_o) begin
      ea = cur_base + 24'(n_issued);
      chk("mem_addr", {8'h0, bus.mem_addr_o}, {8'h0, ea});
      chk("read_in_range", 32'(n_issued < cur_len), 32'd1);
      if (first_en < 0) first_en = cyc_n;
      n_issued++;
      chk("fifo_bound", 32'(n_issued - n_acc <= DEPTH), 32'd1);
    end
    if (held) begin
      chk("hold_rx", {31'h0, rx}, 32'd1);
      chk("hold_data", d, held_data);
    end
    if (rx && cr) begin
      if (first_rx < 0) first_rx = cyc_n;
      last_hs = cyc_n;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      chk("data", d, e);
      ck_m ^= e;
      n_acc++;
    end
    held = rx && !cr;
    held_data = d;
    if (bus.done_o) begin
      done_cyc = cyc_n;
      chk("busy_at_done", {31'h0, bus.busy_o}, 32'd0);
      if (cur_len > 0) chk("done_after_last", cyc_n, last_hs + 1);
    end
  endtask

  task automatic setup(logic [23:0] b, int len, int cm);
    cur_base = b; cur_len = len; cmode = cm;
    n_issued = 0; n_acc = 0; first_rx = -1; first_en = -1; last_hs = -1;
    done_cyc = -1; held = 1'b0; ck_m = '0; saw_busy = 1'b0;
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(mem_word(b + 24'(i)));
    bus.base_addr_i = b;
    bus.length_i = 24'(len);
    pend_start = 1'b1;
  endtask

  task automatic run(logic [23:0] b, int len, int cm, int bound);
    setup(b, len, cm);
    step();
    for (int k = 0; k < bound && done_cyc < 0; k++) step();
    chk("done_seen", 32'(done_cyc >= 0), 32'd1);
    chk("all_words", n_acc, len);
    chk("reads_issued", n_issued, len);
    chk("busy_after", {31'h0, bus.busy_o}, 32'd0);
`ifdef PHIVERS_FEEDER_CKSUM_EN
    chk("cksum", bus.cksum_o, ck_m);
`endif
    poke_cyc = -1;
  endtask

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0; bus.src_credit_i = 1'b0;
    bus.base_addr_i = '0; bus.length_i = '0;
    cmode = 0; cur_len = 0; cur_base = '0; held = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_busy", {31'h0, bus.busy_o}, 0);
    chk("rst_done", {31'h0, bus.done_o}, 0);
    chk("rst_mem_en", {31'h0, bus.mem_en_o}, 0);
    chk("rst_addr", {8'h0, bus.mem_addr_o}, 0);
    chk("rst_rx", {31'h0, bus.src_rx_o}, 0);
    chk("rst_data", bus.src_data_o, 0);
    rst = 1'b0;

    // Basic stream, full credit: latency and 1 word/cycle.
    mem_mode = 0;
    run(24'h000100, 4, 0, 40);
    chk("lat_mem_en", first_en, start_cyc + 1);
    chk("lat_first_rx", first_rx, start_cyc + 3);
    chk("lat_done", done_cyc, start_cyc + 7);
    chk("back_to_back", last_hs - first_rx, 3);

    // Toggling credit, plus a start while busy that must be ignored.
    poke_cyc = cyc_n + 5;
    run(24'h000040, 8, 1, 80);

    // Zero length.
    run(24'h000123, 0, 0, 10);
    chk("len0_done", done_cyc, start_cyc + 1);
    chk("len0_busy", {31'h0, saw_busy}, 0);
    chk("len0_reads", n_issued, 0);

    // Address wrap.
    run(24'hFFFFFE, 4, 0, 40);

    // Reset after two of six words.
    setup(24'h000200, 6, 0);
    step();
    for (int k = 0; k < 40 && n_acc < 2; k++) step();
    chk("pre_rst_acc", n_acc, 2);
    rst = 1'b1;
    @(negedge clk); cyc_n++;
    rst = 1'b0;
    #1;
    chk("abort_busy", {31'h0, bus.busy_o}, 0);
    chk("abort_done", {31'h0, bus.done_o}, 0);
    chk("abort_mem_en", {31'h0, bus.mem_en_o}, 0);
    chk("abort_addr", {8'h0, bus.mem_addr_o}, 0);
    chk("abort_rx", {31'h0, bus.src_rx_o}, 0);
    chk("abort_data", bus.src_data_o, 0);
`ifdef PHIVERS_FEEDER_CKSUM_EN
    chk("abort_cksum", bus.cksum_o, 0);
`endif
    @(negedge clk); cyc_n++; #1;
    chk("abort_inflight_drop", {31'h0, bus.src_rx_o}, 0);
    run(24'h000300, 5, 2, 100);

`ifdef PHIVERS_FEEDER_CKSUM_EN
    mem_mode = 2;
    run(24'h000000, 4, 0, 40);
    chk("cksum_f", bus.cksum_o, 32'hF);
    step(); step(); step();
    chk("cksum_hold", bus.cksum_o, 32'hF);
    run(24'h000000, 2, 0, 40);
`endif

    // Randomized transfers.
    mem_mode = 1;
    for (int t = 0; t < 6; t++)
      run(24'($urandom), int'($urandom_range(1, 20)), 2, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
